// File: rtl/f_accum_pkg.sv
// Shared types and float helpers for the windowed float reducer.
// Helpers take values zero-extended to F_MAX_W bits plus the real widths.
package f_accum_pkg;

    localparam int F_MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_MAX    = 2'b00,
        MODE_MIN    = 2'b01,
        MODE_ABSMAX = 2'b10
    } mode_t;

    // Everything below the sign bit: exponent and mantissa together.
    function automatic logic [F_MAX_W-1:0] mag_of(input logic [F_MAX_W-1:0] v,
                                                  input int data_w);
        logic [F_MAX_W-1:0] mask;
        mask = (F_MAX_W'(1) << (data_w - 1)) - F_MAX_W'(1);
        return v & mask;
    endfunction

    function automatic logic is_nan(input logic [F_MAX_W-1:0] v,
                                    input int data_w,
                                    input int exp_w);
        logic exp_ones;
        logic man_nz;
        exp_ones = 1'b1;
        man_nz   = 1'b0;
        for (int i = 0; i < F_MAX_W; i++) begin
            if (i < data_w - 1 - exp_w) begin
                man_nz = man_nz | v[i];
            end else if (i < data_w - 1) begin
                exp_ones = exp_ones & v[i];
            end
        end
        return exp_ones && man_nz;
    endfunction

    // Strict IEEE greater-than for non-NaN operands; -0 and +0 compare equal.
    function automatic logic float_gt(input logic [F_MAX_W-1:0] a,
                                      input logic [F_MAX_W-1:0] b,
                                      input int data_w);
        logic               sa;
        logic               sb;
        logic [F_MAX_W-1:0] ma;
        logic [F_MAX_W-1:0] mb;
        sa = a[data_w-1];
        sb = b[data_w-1];
        ma = mag_of(a, data_w);
        mb = mag_of(b, data_w);
        if (ma == '0 && mb == '0) begin
            return 1'b0;
        end else if (sa != sb) begin
            return !sa;
        end else if (!sa) begin
            return ma > mb;
        end else begin
            return ma < mb;
        end
    endfunction

endpackage

// File: rtl/f_accum_cmp.sv
// Combinational winner decision: does candidate a displace the held value b?
// NaN candidates never win; a held NaN loses to any non-NaN candidate.
import f_accum_pkg::*;

module f_accum_cmp #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  mode_t             mode,
    output logic              a_wins
);

    logic [F_MAX_W-1:0] a_ext;
    logic [F_MAX_W-1:0] b_ext;
    logic               a_nan;
    logic               b_nan;

    always_comb begin
        a_ext  = F_MAX_W'(a);
        b_ext  = F_MAX_W'(b);
        a_nan  = is_nan(a_ext, DATA_W, EXP_W);
        b_nan  = is_nan(b_ext, DATA_W, EXP_W);
        a_wins = 1'b0;
        if (a_nan) begin
            a_wins = 1'b0;
        end else if (b_nan) begin
            a_wins = 1'b1;
        end else begin
            // Strict compare throughout, so ties keep the earlier element.
            case (mode)
                MODE_MIN:    a_wins = float_gt(b_ext, a_ext, DATA_W);
                MODE_ABSMAX: a_wins = mag_of(a_ext, DATA_W) > mag_of(b_ext, DATA_W);
                default:     a_wins = float_gt(a_ext, b_ext, DATA_W);
            endcase
        end
    end

endmodule

// File: rtl/f_accum_reduce.sv
// Windowed float reducer (MAX / MIN / ABSMAX) over fixed-stride windows.
// Define F_ACCUM_REDUCE_ARGIDX_EN to add the winner-index output out_idx.
import f_accum_pkg::*;

module f_accum_reduce #(
    parameter int DATA_W  = 32,
    parameter int EXP_W   = 8,
    parameter int DELAY_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               running,
    input  logic [1:0]         mode,
    input  logic [DELAY_W-1:0] strideMinusOne,
    input  logic [DELAY_W-1:0] delay0,
    input  logic [DATA_W-1:0]  in0,
    output logic [DATA_W-1:0]  out0,
    output logic               out_valid
`ifdef F_ACCUM_REDUCE_ARGIDX_EN
    ,
    output logic [DELAY_W-1:0] out_idx
`endif
);

    logic [DELAY_W-1:0] delay_q;
    logic [DELAY_W-1:0] delay_d;
    logic [DATA_W-1:0]  stored_q;
    logic [DATA_W-1:0]  stored_d;
    logic               primed_q;
    logic               primed_d;
    mode_t              mode_q;
    mode_t              mode_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic               store;
    logic               last;
    logic               in_wins;

    f_accum_cmp #(
        .DATA_W (DATA_W),
        .EXP_W  (EXP_W)
    ) u_cmp (
        .a      (in0),
        .b      (stored_q),
        .mode   (mode_q),
        .a_wins (in_wins)
    );

    always_comb begin
        delay_d  = delay_q;
        stored_d = stored_q;
        primed_d = primed_q;
        mode_d   = mode_q;
        last     = 1'b0;
        store    = (delay_q == '0);

        // The counter keeps turning even while running is low.
        if (run) begin
            delay_d = delay0;
        end else if (!store) begin
            delay_d = delay_q - 1'b1;
        end else begin
            delay_d = strideMinusOne;
        end

        // run has priority: the sample presented with it is not folded in.
        if (run) begin
            mode_d   = mode_t'(mode);
            primed_d = 1'b0;
        end else if (running) begin
            if (store) begin
                stored_d = in0;
                primed_d = 1'b1;
                last     = (strideMinusOne == '0);
            end else begin
                if (in_wins) begin
                    stored_d = in0;
                end
                last = primed_q && (delay_q == DELAY_W'(1));
            end
        end

        out_valid_d = last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delay_q     <= '0;
            stored_q    <= '0;
            primed_q    <= 1'b0;
            mode_q      <= MODE_MAX;
            out_valid_q <= 1'b0;
        end else begin
            delay_q     <= delay_d;
            stored_q    <= stored_d;
            primed_q    <= primed_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    // out_valid is a one-cycle pulse with no back-pressure: out0 carries the
    // finished window result exactly in the cycle out_valid is high.
    assign out0      = stored_q;
    assign out_valid = out_valid_q;

`ifdef F_ACCUM_REDUCE_ARGIDX_EN
    logic [DELAY_W-1:0] idx_q;
    logic [DELAY_W-1:0] idx_d;
    logic [DELAY_W-1:0] win_idx_q;
    logic [DELAY_W-1:0] win_idx_d;
    logic [DELAY_W-1:0] out_idx_q;
    logic [DELAY_W-1:0] out_idx_d;

    always_comb begin
        idx_d     = idx_q;
        win_idx_d = win_idx_q;
        if (run) begin
            idx_d     = '0;
            win_idx_d = '0;
        end else if (running) begin
            if (store) begin
                idx_d     = '0;
                win_idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
                if (in_wins) begin
                    win_idx_d = idx_q + 1'b1;
                end
            end
        end
        // Capture the index including the final element's own decision.
        out_idx_d = last ? win_idx_d : out_idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            win_idx_q <= '0;
            out_idx_q <= '0;
        end else begin
            idx_q     <= idx_d;
            win_idx_q <= win_idx_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign out_idx = out_idx_q;
`endif

endmodule

// File: tb/tb_f_accum_reduce.sv
// Bench for f_accum_reduce: directed window table, corner sequences, random run vs model.
module tb_f_accum_reduce;

    localparam int DATA_W  = 32;
    localparam int EXP_W   = 8;
    localparam int DELAY_W = 7;

    logic               clk;
    logic               rst_n;
    logic               run;
    logic               running;
    logic [1:0]         mode;
    logic [DELAY_W-1:0] stride_m1;
    logic [DELAY_W-1:0] delay0;
    logic [DATA_W-1:0]  in0;
    logic [DATA_W-1:0]  out0;
    logic               out_valid;
    logic [DELAY_W-1:0] out_idx;

    int total;
    int bad;

    f_accum_reduce #(
        .DATA_W  (DATA_W),
        .EXP_W   (EXP_W),
        .DELAY_W (DELAY_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .running        (running),
        .mode           (mode),
        .strideMinusOne (stride_m1),
        .delay0         (delay0),
        .in0            (in0),
        .out0           (out0),
        .out_valid      (out_valid)
`ifdef F_ACCUM_REDUCE_ARGIDX_EN
        ,
        .out_idx        (out_idx)
`endif
    );

`ifndef F_ACCUM_REDUCE_ARGIDX_EN
    assign out_idx = '0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference helpers ----------------
    function automatic bit f_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    function automatic real f2r(input logic [31:0] b);
        int  e;
        real m;
        real v;
        e = int'(b[30:23]);
        m = real'(b[22:0]) / 8388608.0;
        if (e == 255)    v = 1.0e300;
        else if (e == 0) v = m * (2.0 ** (-126));
        else             v = (1.0 + m) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic real rabs(input real r);
        return (r < 0.0) ? -r : r;
    endfunction

    function automatic bit better(input logic [31:0] x, input logic [31:0] cur, input logic [1:0] m);
        real rx;
        real rc;
        if (f_nan(x))   return 1'b0;
        if (f_nan(cur)) return 1'b1;
        rx = f2r(x);
        rc = f2r(cur);
        case (m)
            2'd1:    return rx < rc;
            2'd2:    return rabs(rx) > rabs(rc);
            default: return rx > rc;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rn, input logic [31:0] d);
        run     = r;
        running = rn;
        in0     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b1, 32'h4120_0000);
        step(1'b0, 1'b1, 32'h4120_0000);
        rst_n = 1'b1;
    endtask

    task automatic start(input logic [1:0] m, input logic [DELAY_W-1:0] s, input logic [DELAY_W-1:0] d0);
        mode      = m;
        stride_m1 = s;
        delay0    = d0;
        step(1'b1, 1'b0, 32'h0);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [1:0]       mode;
        logic [3:0][31:0] d;
        logic [31:0]      exp_out;
        logic [6:0]       exp_idx;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3,
                                input logic [31:0] e, input logic [6:0] ix);
        vec_t v;
        v.mode    = m;
        v.d[0]    = a0;
        v.d[1]    = a1;
        v.d[2]    = a2;
        v.d[3]    = a3;
        v.exp_out = e;
        v.exp_idx = ix;
        return v;
    endfunction

    vec_t vecs [12];

    // ---------------- random phase scoreboard ----------------
    logic [31:0] pool [12];
    logic [31:0] exp_q [$];
    logic [31:0] win [$];

    initial begin
        logic [31:0] d;
        int          cnt;
        bit          primed;
        bit          exp_valid;
        logic [1:0]  m_mode;
        int          best;
        logic        r;
        logic        rn;
        logic [31:0] e_out;
        logic [6:0]  e_idx;

        total   = 0;
        bad     = 0;
        run     = 1'b0;
        running = 1'b0;
        mode    = 2'd0;
        stride_m1 = '0;
        delay0  = '0;
        in0     = '0;
        rst_n   = 1'b0;

        // reset state, with run/running asserted during reset
        do_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b1, 32'h4120_0000);
        chk("reset_out0", out0, 32'h0);
        chk("reset_valid", {31'd0, out_valid}, 32'h0);
`ifdef F_ACCUM_REDUCE_ARGIDX_EN
        chk("reset_idx", {25'd0, out_idx}, 32'h0);
`endif
        rst_n = 1'b1;

        vecs[0]  = mk(2'd0, 32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40200000, 32'h40400000, 7'd2);
        vecs[1]  = mk(2'd1, 32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40200000, 32'hC0000000, 7'd1);
        vecs[2]  = mk(2'd2, 32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40200000, 32'h40400000, 7'd2);
        vecs[3]  = mk(2'd0, 32'hC0A00000, 32'hBF800000, 32'hC0400000, 32'hBF800000, 32'hBF800000, 7'd1);
        vecs[4]  = mk(2'd0, 32'h7FC00000, 32'h40000000, 32'h7FC00000, 32'h3F800000, 32'h40000000, 7'd1);
        vecs[5]  = mk(2'd0, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000, 7'd0);
        vecs[6]  = mk(2'd1, 32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 7'd0);
        vecs[7]  = mk(2'd0, 32'h3F800000, 32'h7F800000, 32'h40000000, 32'hFF800000, 32'h7F800000, 7'd1);
        vecs[8]  = mk(2'd1, 32'h3F800000, 32'h7F800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 7'd3);
        vecs[9]  = mk(2'd2, 32'h3F800000, 32'hC0800000, 32'h40400000, 32'h40800000, 32'hC0800000, 7'd1);
        vecs[10] = mk(2'd3, 32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40200000, 32'h40400000, 7'd2);
        vecs[11] = mk(2'd1, 32'h7FC00000, 32'hBF800000, 32'h7FC00000, 32'h40000000, 32'hBF800000, 7'd1);

        for (int i = 0; i < 12; i++) begin
            do_reset();
            start(vecs[i].mode, 7'd3, 7'd0);
            for (int k = 0; k < 4; k++) begin
                step(1'b0, 1'b1, vecs[i].d[k]);
                chk($sformatf("vec%0d_valid%0d", i, k), {31'd0, out_valid}, {31'd0, k == 3});
            end
            chk($sformatf("vec%0d_out0", i), out0, vecs[i].exp_out);
`ifdef F_ACCUM_REDUCE_ARGIDX_EN
            chk($sformatf("vec%0d_idx", i), {25'd0, out_idx}, {25'd0, vecs[i].exp_idx});
`endif
            step(1'b0, 1'b0, 32'h41200000);
            chk($sformatf("vec%0d_hold", i), {31'd0, out_valid}, 32'h0);
            chk($sformatf("vec%0d_hold0", i), out0, vecs[i].exp_out);
        end

        // stride 0 with delay0 = 2
        do_reset();
        start(2'd0, 7'd0, 7'd2);
        step(1'b0, 1'b1, 32'h40E00000);
        chk("s0_v7", {31'd0, out_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h41000000);
        chk("s0_v8", {31'd0, out_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h41100000);
        chk("s0_v9", {31'd0, out_valid}, 32'h1);
        chk("s0_o9", out0, 32'h41100000);
        step(1'b0, 1'b1, 32'h41200000);
        chk("s0_v10", {31'd0, out_valid}, 32'h1);
        chk("s0_o10", out0, 32'h41200000);

        // reset mid-window while running
        do_reset();
        start(2'd0, 7'd3, 7'd0);
        step(1'b0, 1'b1, 32'h40400000);
        step(1'b0, 1'b1, 32'h40800000);
        rst_n = 1'b0;
        step(1'b0, 1'b1, 32'h41000000);
        chk("midrst_out0", out0, 32'h0);
        chk("midrst_valid", {31'd0, out_valid}, 32'h0);
        rst_n = 1'b1;

        // run mid-window drops the partial window
        do_reset();
        start(2'd0, 7'd3, 7'd0);
        step(1'b0, 1'b1, 32'h3F800000);
        step(1'b0, 1'b1, 32'h40A00000);
        mode = 2'd0;
        delay0 = 7'd0;
        step(1'b1, 1'b1, 32'h41200000);
        chk("rerun_v_run", {31'd0, out_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h40000000);
        chk("rerun_v0", {31'd0, out_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h3F800000);
        chk("rerun_v1", {31'd0, out_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h40400000);
        chk("rerun_v2", {31'd0, out_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h40200000);
        chk("rerun_v3", {31'd0, out_valid}, 32'h1);
        chk("rerun_out0", out0, 32'h40400000);
`ifdef F_ACCUM_REDUCE_ARGIDX_EN
        chk("rerun_idx", {25'd0, out_idx}, 32'd2);
`endif

        // randomized run against the reference model
        pool[0] = 32'h3F800000; pool[1]  = 32'hBF800000; pool[2]  = 32'h40000000;
        pool[3] = 32'hC0000000; pool[4]  = 32'h00000000; pool[5]  = 32'h80000000;
        pool[6] = 32'h7F800000; pool[7]  = 32'hFF800000; pool[8]  = 32'h7FC00000;
        pool[9] = 32'h40400000; pool[10] = 32'hC0400000; pool[11] = 32'h00000001;

        do_reset();
        cnt    = 0;
        primed = 1'b0;
        m_mode = 2'd0;
        for (int c = 0; c < 4000; c++) begin
            r  = (c == 0) || ($urandom_range(0, 59) == 0);
            rn = ($urandom_range(0, 7) != 0);
            d  = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 11)] : $urandom;
            if (r) begin
                mode      = 2'($urandom_range(0, 3));
                stride_m1 = 7'($urandom_range(0, 5));
                delay0    = 7'($urandom_range(0, 4));
            end

            exp_valid = 1'b0;
            if (r) begin
                cnt    = int'(delay0);
                m_mode = mode;
                primed = 1'b0;
                win.delete();
            end else begin
                if (rn) begin
                    if (cnt == 0) begin
                        win.delete();
                        win.push_back(d);
                        primed = 1'b1;
                        exp_valid = (stride_m1 == 0);
                    end else if (primed) begin
                        win.push_back(d);
                        exp_valid = (cnt == 1);
                    end
                end
                cnt = (cnt == 0) ? int'(stride_m1) : cnt - 1;
            end

            step(r, rn, d);

            chk($sformatf("rnd%0d_valid", c), {31'd0, out_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                best = 0;
                for (int k = 1; k < win.size(); k++) begin
                    if (better(win[k], win[best], m_mode)) best = k;
                end
                e_out = win[best];
                e_idx = 7'(best);
                exp_q.push_back(e_out);
                chk($sformatf("rnd%0d_out0", c), out0, exp_q.pop_front());
`ifdef F_ACCUM_REDUCE_ARGIDX_EN
                chk($sformatf("rnd%0d_idx", c), {25'd0, out_idx}, {25'd0, e_idx});
`endif
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
